// File: rtl/data_sched_pkg.sv
// Shared hunter packet definitions: BAG codes, packet lengths, buffer bases,
// fd timeout default and the scheduler state/packet enums.
package data_sched_pkg;

  localparam logic [11:0] TMO_MAX_DEF   = 12'hFFF;
  localparam logic [11:0] BUF0_BASE_DEF = 12'h000;
  localparam logic [11:0] BUF1_BASE_DEF = 12'h800;

  localparam logic [3:0] BAG_DLINK = 4'b1000;
  localparam logic [3:0] BAG_DTYPE = 4'b1001;
  localparam logic [3:0] BAG_DTEMP = 4'b1010;
  localparam logic [3:0] BAG_DATA0 = 4'b1101;
  localparam logic [3:0] BAG_DATA1 = 4'b1110;

  localparam int CHIPS      = 8;
  localparam int CHIP_BYTES = 64;
  localparam logic [9:0] LEN_CTRL = 10'd2;
  localparam logic [9:0] LEN_DATA = 10'(2 + CHIPS * CHIP_BYTES);

  typedef enum logic [1:0] {ST_IDLE, ST_MAKE, ST_RELS, ST_POST} state_e;
  typedef enum logic [1:0] {PKT_DLINK, PKT_DTYPE, PKT_DTEMP, PKT_DATA} pkt_e;

  // DATA packets alternate between two codes, selected by the toggle bit
  function automatic logic [3:0] bag_code(input pkt_e p, input logic dtog);
    case (p)
      PKT_DLINK: bag_code = BAG_DLINK;
      PKT_DTYPE: bag_code = BAG_DTYPE;
      PKT_DTEMP: bag_code = BAG_DTEMP;
      default:   bag_code = dtog ? BAG_DATA1 : BAG_DATA0;
    endcase
  endfunction

  function automatic logic [9:0] pkt_len(input pkt_e p);
    pkt_len = (p == PKT_DATA) ? LEN_DATA : LEN_CTRL;
  endfunction

endpackage

// File: rtl/data_sched_buf.sv
// Ping-pong buffer tracker: next buffer to fill plus per-buffer busy flags.
module data_sched_buf (
  input  logic       clk,
  input  logic       rst,
  input  logic       post_i,
  input  logic       done_i,
  input  logic       done_buf_i,
  output logic       wr_sel_o,
  output logic [1:0] busy_o
);

  logic       wr_sel_q, wr_sel_d;
  logic [1:0] busy_q, busy_d;
  logic [1:0] set_v, clr_v;

  // A post and a release of the same buffer in one cycle leaves it busy
  always_comb begin
    set_v = '0;
    clr_v = '0;
    if (post_i) set_v[wr_sel_q] = 1'b1;
    if (done_i) clr_v[done_buf_i] = 1'b1;
    busy_d   = (busy_q & ~clr_v) | set_v;
    wr_sel_d = wr_sel_q ^ post_i;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_sel_q <= 1'b0;
      busy_q   <= '0;
    end else begin
      wr_sel_q <= wr_sel_d;
      busy_q   <= busy_d;
    end
  end

  assign wr_sel_o = wr_sel_q;
  assign busy_o   = busy_q;

endmodule

// File: rtl/data_sched.sv
// Packet scheduler: arbitrates request pulses, drives the packet maker and
// posts finished ping-pong buffers to the transmitter.
module data_sched
  import data_sched_pkg::*;
#(
  parameter logic [11:0] TMO_MAX   = TMO_MAX_DEF,
  parameter logic [11:0] BUF0_BASE = BUF0_BASE_DEF,
  parameter logic [11:0] BUF1_BASE = BUF1_BASE_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req,
  output logic        fs,
  output logic [3:0]  btype,
  output logic [11:0] ram_data_init,
  input  logic        fd,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic [11:0] tx_addr,
  output logic [9:0]  tx_len,
  output logic        tx_buf,
  input  logic        tx_done,
  input  logic        tx_done_buf,
  output logic        err_tmo,
  output logic        busy
);

  state_e      state_q, state_d;
  pkt_e        grant_q, grant_d, arb_pkt;
  logic        gvld_q, gvld_d;
  logic [3:0]  pend_q, pend_d, pend_clr;
  logic        dtog_q, dtog_d;
  logic [11:0] cnt_q, cnt_d;
  logic        fs_q, fs_d, txv_q, txv_d, tmo_q, tmo_d, txb_q, txb_d;
  logic [3:0]  btype_q, btype_d;
  logic [11:0] rdi_q, rdi_d, txa_q, txa_d;
  logic [9:0]  txl_q, txl_d;
  logic        post, wr_sel;
  logic [1:0]  buf_busy;
  logic [11:0] wr_base;

  data_sched_buf u_buf (
    .clk        (clk),
    .rst        (rst),
    .post_i     (post),
    .done_i     (tx_done),
    .done_buf_i (tx_done_buf),
    .wr_sel_o   (wr_sel),
    .busy_o     (buf_busy)
  );

  assign wr_base = wr_sel ? BUF1_BASE : BUF0_BASE;

  always_comb begin
    arb_pkt = PKT_DATA;
    if (pend_q[0])      arb_pkt = PKT_DLINK;
    else if (pend_q[1]) arb_pkt = PKT_DTYPE;
    else if (pend_q[2]) arb_pkt = PKT_DTEMP;
  end

  // A timeout drops the grant, so gvld_q doubles as the "post after release" flag
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    gvld_d   = gvld_q;
    dtog_d   = dtog_q;
    cnt_d    = cnt_q;
    fs_d     = fs_q;
    btype_d  = btype_q;
    rdi_d    = rdi_q;
    txv_d    = txv_q;
    txa_d    = txa_q;
    txl_d    = txl_q;
    txb_d    = txb_q;
    tmo_d    = 1'b0;
    pend_clr = '0;
    post     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if ((|pend_q) && !buf_busy[wr_sel]) begin
          grant_d  = arb_pkt;
          gvld_d   = 1'b1;
          pend_clr = 4'b0001 << arb_pkt;
          btype_d  = bag_code(arb_pkt, dtog_q);
          rdi_d    = wr_base;
          fs_d     = 1'b1;
          cnt_d    = '0;
          state_d  = ST_MAKE;
        end
      end
      ST_MAKE: begin
        if (fd) begin
          fs_d    = 1'b0;
          state_d = ST_RELS;
        end else if (cnt_q == TMO_MAX - 12'd1) begin
          fs_d    = 1'b0;
          tmo_d   = 1'b1;
          gvld_d  = 1'b0;
          state_d = ST_RELS;
        end else begin
          cnt_d = cnt_q + 12'd1;
        end
      end
      ST_RELS: begin
        if (!fd) begin
          if (gvld_q) begin
            txv_d   = 1'b1;
            txa_d   = wr_base;
            txl_d   = pkt_len(grant_q);
            txb_d   = wr_sel;
            state_d = ST_POST;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        if (tx_ready) begin
          post    = 1'b1;
          txv_d   = 1'b0;
          gvld_d  = 1'b0;
          if (grant_q == PKT_DATA) dtog_d = ~dtog_q;
          state_d = ST_IDLE;
        end
      end
    endcase
    pend_d = (pend_q & ~pend_clr) | req;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      grant_q <= PKT_DLINK;
      gvld_q  <= 1'b0;
      pend_q  <= '0;
      dtog_q  <= 1'b0;
      cnt_q   <= '0;
      fs_q    <= 1'b0;
      btype_q <= '0;
      rdi_q   <= BUF0_BASE;
      txv_q   <= 1'b0;
      txa_q   <= '0;
      txl_q   <= '0;
      txb_q   <= 1'b0;
      tmo_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gvld_q  <= gvld_d;
      pend_q  <= pend_d;
      dtog_q  <= dtog_d;
      cnt_q   <= cnt_d;
      fs_q    <= fs_d;
      btype_q <= btype_d;
      rdi_q   <= rdi_d;
      txv_q   <= txv_d;
      txa_q   <= txa_d;
      txl_q   <= txl_d;
      txb_q   <= txb_d;
      tmo_q   <= tmo_d;
    end
  end

  assign fs            = fs_q;
  assign btype         = btype_q;
  assign ram_data_init = rdi_q;
  assign tx_valid      = txv_q;
  assign tx_addr       = txa_q;
  assign tx_len        = txl_q;
  assign tx_buf        = txb_q;
  assign err_tmo       = tmo_q;
  assign busy          = (state_q != ST_IDLE);

endmodule

// File: doc/data_sched.md
DATA_SCHED -- requirements
Module: data_sched

Interface
REQ-001 SHALL have parameter TMO_MAX, default 12'hFFF, the fd timeout limit in clk cycles.
REQ-002 SHALL have parameter BUF0_BASE, default 12'h000, the ping buffer base address.
REQ-003 SHALL have parameter BUF1_BASE, default 12'h800, the pong buffer base address.
REQ-004 clk  in  1  single system clock, all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-low reset.
REQ-006 req  in  4  one-cycle request pulses: [0] DLINK, [1] DTYPE, [2] DTEMP, [3] DATA.
REQ-007 fs  out  1  start to the packet maker, held high until fd.
REQ-008 btype  out  4  packet code to the maker; valid while fs is high.
REQ-009 ram_data_init  out  12  write base address for the maker; valid while fs is high.
REQ-010 fd  in  1  maker done level.
REQ-011 tx_valid  out  1  buffer post to the transmitter.
REQ-012 tx_ready  in  1  transmitter accepts the post.
REQ-013 tx_addr  out  12  base address of the posted buffer.
REQ-014 tx_len  out  10  byte count of the posted buffer.
REQ-015 tx_buf  out  1  index of the posted buffer.
REQ-016 tx_done  in  1  one-cycle pulse: the transmitter has finished the buffer tx_done_buf.
REQ-017 tx_done_buf  in  1  index of the buffer released by tx_done.
REQ-018 err_tmo  out  1  one-cycle pulse on an fd timeout.
REQ-019 busy  out  1  high whenever state is not IDLE.

Function
REQ-020 A req pulse SHALL set its pending bit; a grant SHALL clear it; if a set and a clear of the same bit coincide, the set SHALL win.
REQ-021 Fixed priority SHALL be DLINK > DTYPE > DTEMP > DATA.
REQ-022 btype SHALL be 4'b1000 for DLINK, 4'b1001 for DTYPE and 4'b1010 for DTEMP.
REQ-023 For DATA, btype SHALL alternate 4'b1101/4'b1110, starting at 4'b1101 after reset; the toggle SHALL advance only on a successful post.
REQ-024 tx_len SHALL be 2 for DLINK, DTYPE and DTEMP, and 514 (2 + 8 chips x 64) for DATA.
REQ-025 Two buffers SHALL be tracked: wr_sel (the next buffer to fill, reset 0) and busy0/busy1 flags (reset 0).
REQ-026 The state machine states SHALL be IDLE, MAKE, RELS, POST.
REQ-027 IDLE: when any bit is pending and busy[wr_sel]=0, the block SHALL latch the grant, btype and ram_data_init = base(wr_sel), assert fs and enter MAKE on the next edge.
REQ-028 IDLE: when busy[wr_sel]=1, the block SHALL stall in IDLE and keep the pending bits.
REQ-029 fs SHALL rise no later than 2 cycles after a req pulse when the block is idle and the buffer is free.
REQ-030 MAKE: the block SHALL hold fs=1 and count cycles.
REQ-031 MAKE: on fd=1 the block SHALL drop fs and enter RELS.
REQ-032 MAKE: on count reaching TMO_MAX without fd, the block SHALL drop fs, pulse err_tmo, leave the buffer not busy, leave wr_sel unchanged, drop the grant, and enter RELS.
REQ-033 RELS: the block SHALL wait for fd=0.
REQ-034 RELS: on fd=0 the block SHALL enter POST for a normal completion, or IDLE after a timeout.
REQ-035 POST: the block SHALL assert tx_valid with tx_addr, tx_len and tx_buf stable until tx_ready=1.
REQ-036 POST: on the accept cycle the block SHALL set busy[wr_sel], toggle wr_sel, drop tx_valid and return to IDLE.
REQ-037 tx_done SHALL clear busy[tx_done_buf] in any state.
REQ-038 If tx_done and a busy-set for the same buffer coincide, the set SHALL win.
REQ-039 ram_data_init, btype, tx_addr, tx_len and tx_buf SHALL be registered.
REQ-040 fs, tx_valid and err_tmo SHALL be registered, glitch-free outputs.
REQ-041 fd seen while in IDLE or POST SHALL be ignored.
REQ-042 Simultaneous req pulses SHALL all become pending and be served one per packet, in priority order.

Reset
REQ-043 While rst=0, outputs SHALL be: fs=0, btype=0, ram_data_init=BUF0_BASE, tx_valid=0, tx_addr=0, tx_len=0, tx_buf=0, err_tmo=0, busy=0.
REQ-044 While rst=0, internal state SHALL be: pending=0, busy0=busy1=0, wr_sel=0, DATA toggle reset, timeout counter=0, state=IDLE.
REQ-045 Reset asserted mid-packet SHALL abort it immediately, with no post and no err_tmo.

Structure
REQ-046 The BAG codes, the packet lengths, BUF0_BASE/BUF1_BASE defaults and TMO_MAX default SHALL live in the shared hunter packet package.
REQ-047 The ping-pong busy/wr_sel tracker SHALL be the single sub-module data_sched_buf; the arbiter and the state machine SHALL stay in data_sched.

Verification
REQ-048 req=4'b0001; fd returned 3 cycles after fs -> btype=8, ram_data_init=000, then tx_valid with tx_addr=000, tx_len=2, tx_buf=0.
REQ-049 req=4'b1111 in one cycle -> packets issued in order DLINK, DTYPE, DTEMP, DATA(btype=D), using buffers 0,1,0,1.
REQ-050 Two DATA requests with no tx_done -> second packet uses buffer 1 with btype=E; a third request stalls in IDLE until tx_done with tx_done_buf=0.
REQ-051 fd never returned -> err_tmo pulses exactly TMO_MAX cycles after fs rises, fs=0, no tx_valid, next packet reuses the same buffer.
REQ-052 tx_ready held 0 for 10 cycles -> tx_valid, tx_addr and tx_len stay stable; post completes on the first cycle tx_ready=1.
REQ-053 rst pulsed low during MAKE of a DATA packet -> all outputs return to their reset values at once; pending is cleared; the next DATA packet uses btype=D.
